// File: rtl/control_queue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : control_queue_arbiter
// Purpose  : Round-robin arbiter. It shares one control queue FIFO among
//            PORT_NUM requesters. Each requester has a 2-entry buffer, and
//            overflowing descriptors are returned on a per-port drop channel.
// Revision : 1.0 - initial release
// ============================================================================
module control_queue_arbiter #(
    parameter int PORT_NUM   = 4,
    parameter int FIFO_DEPTH = 256,
    parameter int USEDW_W    = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [PORT_NUM*14-1:0] iv_req_data,
    input  logic [PORT_NUM-1:0]   iv_req_wr,
    input  logic [USEDW_W-1:0]    iv_fifo_usedw,
    output logic [13:0]           ov_fifo_wdata,
    output logic                  o_fifo_wr,
    output logic [PORT_NUM*9-1:0] ov_drop_bufid,
    output logic [PORT_NUM-1:0]   ov_drop_wr,
    output logic [15:0]           ov_drop_cnt
);

    localparam int               c_ptr_w      = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam logic [USEDW_W:0] c_fifo_depth = (USEDW_W+1)'(FIFO_DEPTH);

    logic [13:0]         r_buf [PORT_NUM][2];
    logic [1:0]          r_cnt [PORT_NUM];
    logic [PORT_NUM-1:0] r_wp;
    logic [PORT_NUM-1:0] r_rp;
    logic [c_ptr_w-1:0]  r_rr_ptr;
    logic [13:0]         r_fifo_wdata;
    logic                r_fifo_wr;
    logic [8:0]          r_drop_bufid [PORT_NUM];
    logic [PORT_NUM-1:0] r_drop_wr;
    logic [15:0]         r_drop_cnt;

    logic                w_elig;
    logic                w_found;
    logic [c_ptr_w-1:0]  w_gnt_idx;
    logic [c_ptr_w-1:0]  w_rr_next;
    logic [13:0]         w_gnt_data;
    logic [PORT_NUM-1:0] w_nonempty;
    logic [PORT_NUM-1:0] w_pop;
    logic [PORT_NUM-1:0] w_acc;
    logic [PORT_NUM-1:0] w_drop;
    logic [3:0]          w_drop_num;
    logic [16:0]         w_drop_sum;
    int                  w_scan_idx;

    // The write issued last cycle is not yet reflected in usedw, so count it here.
    assign w_elig = ({1'b0, iv_fifo_usedw} + {{USEDW_W{1'b0}}, r_fifo_wr}) < c_fifo_depth;

    always_comb begin
        w_nonempty = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            w_nonempty[p] = (r_cnt[p] != 2'd0);
        end
    end

    always_comb begin
        w_found    = 1'b0;
        w_gnt_idx  = '0;
        w_scan_idx = 0;
        for (int i = 0; i < PORT_NUM; i++) begin
            w_scan_idx = int'(r_rr_ptr) + i;
            if (w_scan_idx >= PORT_NUM) begin
                w_scan_idx = w_scan_idx - PORT_NUM;
            end
            if (w_elig && !w_found && w_nonempty[c_ptr_w'(w_scan_idx)]) begin
                w_found   = 1'b1;
                w_gnt_idx = c_ptr_w'(w_scan_idx);
            end
        end
    end

    assign w_gnt_data = r_buf[w_gnt_idx][r_rp[w_gnt_idx]];
    assign w_rr_next  = (int'(w_gnt_idx) == PORT_NUM - 1) ? '0 : w_gnt_idx + 1'b1;

    // A full buffer still accepts a push when its head leaves in the same cycle.
    always_comb begin
        w_pop      = '0;
        w_acc      = '0;
        w_drop     = '0;
        w_drop_num = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            w_pop[p]   = w_found && (w_gnt_idx == c_ptr_w'(p));
            w_acc[p]   = iv_req_wr[p] && ((r_cnt[p] != 2'd2) || w_pop[p]);
            w_drop[p]  = iv_req_wr[p] && (r_cnt[p] == 2'd2) && !w_pop[p];
            w_drop_num = w_drop_num + 4'(w_drop[p]);
        end
    end

    assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_num);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_rr_ptr     <= '0;
            r_fifo_wdata <= '0;
            r_fifo_wr    <= 1'b0;
            r_drop_wr    <= '0;
            r_drop_cnt   <= '0;
            for (int p = 0; p < PORT_NUM; p++) begin
                r_cnt[p]        <= 2'd0;
                r_drop_bufid[p] <= 9'd0;
            end
        end else begin
            r_fifo_wr    <= w_found;
            r_fifo_wdata <= w_found ? w_gnt_data : 14'd0;
            if (w_found) begin
                r_rr_ptr <= w_rr_next;
            end
            for (int p = 0; p < PORT_NUM; p++) begin
                if (w_acc[p]) begin
                    r_buf[p][r_wp[p]] <= iv_req_data[p*14 +: 14];
                    r_wp[p]           <= ~r_wp[p];
                end
                if (w_pop[p]) begin
                    r_rp[p] <= ~r_rp[p];
                end
                r_cnt[p]        <= r_cnt[p] + {1'b0, w_acc[p]} - {1'b0, w_pop[p]};
                r_drop_wr[p]    <= w_drop[p];
                r_drop_bufid[p] <= w_drop[p] ? iv_req_data[p*14 +: 9] : 9'd0;
            end
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    generate
        for (genvar g = 0; g < PORT_NUM; g++) begin : g_drop_out
            assign ov_drop_bufid[g*9 +: 9] = r_drop_bufid[g];
        end
    endgenerate

    assign ov_fifo_wdata = r_fifo_wdata;
    assign o_fifo_wr     = r_fifo_wr;
    assign ov_drop_wr    = r_drop_wr;
    assign ov_drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_control_queue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_queue_arbiter
// Purpose  : Directed self-checking bench for control_queue_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_queue_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [55:0] req_data;
    logic [3:0]  req_wr;
    logic [8:0]  usedw;
    logic [13:0] fifo_wdata;
    logic        fifo_wr;
    logic [35:0] drop_bufid;
    logic [3:0]  drop_wr;
    logic [15:0] drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    control_queue_arbiter #(
        .PORT_NUM   (4),
        .FIFO_DEPTH (256),
        .USEDW_W    (9)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .iv_req_data   (req_data),
        .iv_req_wr     (req_wr),
        .iv_fifo_usedw (usedw),
        .ov_fifo_wdata (fifo_wdata),
        .o_fifo_wr     (fifo_wr),
        .ov_drop_bufid (drop_bufid),
        .ov_drop_wr    (drop_wr),
        .ov_drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] desc(input logic hit, input logic [3:0] inport, input logic [8:0] bufid);
        return {hit, inport, bufid};
    endfunction

    task automatic strobe(input int p, input logic [13:0] d);
        req_wr[p]          = 1'b1;
        req_data[p*14 +: 14] = d;
    endtask

    task automatic idle();
        req_wr = '0;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req_wr = '0;
        step();
        rst    = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        req_data = '0;
        req_wr   = '0;
        usedw    = '0;
        step();
        step();
        chk("rst_fifo_wr",   32'(fifo_wr),    32'd0);
        chk("rst_fifo_data", 32'(fifo_wdata), 32'd0);
        chk("rst_drop_wr",   32'(drop_wr),    32'd0);
        chk("rst_drop_cnt",  32'(drop_cnt),   32'd0);
        rst = 1'b0;

        // Single request: latency 2
        strobe(0, desc(1'b1, 4'd3, 9'h005));
        step();
        idle();
        chk("single_t1_wr", 32'(fifo_wr), 32'd0);
        step();
        chk("single_t2_wr",   32'(fifo_wr),    32'd1);
        chk("single_t2_data", 32'(fifo_wdata), 32'h2605);
        step();
        chk("single_t3_wr", 32'(fifo_wr), 32'd0);

        // Fairness
        do_reset();
        for (int p = 0; p < 4; p++) strobe(p, desc(1'b0, 4'(p), 9'(16 + p)));
        step();
        idle();
        chk("fair_lat_wr", 32'(fifo_wr), 32'd0);
        for (int p = 0; p < 4; p++) begin
            step();
            chk("fair_wr",   32'(fifo_wr),    32'd1);
            chk("fair_data", 32'(fifo_wdata), 32'(desc(1'b0, 4'(p), 9'(16 + p))));
        end
        step();
        chk("fair_done_wr", 32'(fifo_wr), 32'd0);
        strobe(0, desc(1'b0, 4'd0, 9'd32));
        strobe(2, desc(1'b0, 4'd2, 9'd34));
        step();
        idle();
        step();
        chk("fair2_p0", 32'(fifo_wdata), 32'(desc(1'b0, 4'd0, 9'd32)));
        step();
        chk("fair2_p2", 32'(fifo_wdata), 32'(desc(1'b0, 4'd2, 9'd34)));
        step();
        chk("fair2_done_wr", 32'(fifo_wr), 32'd0);

        // Overflow with FIFO full
        usedw = 9'd256;
        strobe(1, desc(1'b0, 4'd1, 9'd1));
        step();
        chk("ovf_b1_drop", 32'(drop_wr), 32'd0);
        strobe(1, desc(1'b0, 4'd1, 9'd2));
        step();
        chk("ovf_b2_drop", 32'(drop_wr), 32'd0);
        strobe(1, desc(1'b0, 4'd1, 9'd3));
        step();
        idle();
        chk("ovf_drop_wr",    32'(drop_wr),          32'b0010);
        chk("ovf_drop_bufid", 32'(drop_bufid[17:9]), 32'd3);
        chk("ovf_drop_cnt",   32'(drop_cnt),         32'd1);
        chk("ovf_fifo_wr",    32'(fifo_wr),          32'd0);
        step();
        chk("ovf_drop_pulse", 32'(drop_wr),  32'd0);
        chk("ovf_cnt_hold",   32'(drop_cnt), 32'd1);
        chk("ovf_stall_wr",   32'(fifo_wr),  32'd0);
        usedw = 9'd0;
        step();
        chk("ovf_w1_wr",   32'(fifo_wr),    32'd1);
        chk("ovf_w1_data", 32'(fifo_wdata), 32'(desc(1'b0, 4'd1, 9'd1)));
        step();
        chk("ovf_w2_data", 32'(fifo_wdata), 32'(desc(1'b0, 4'd1, 9'd2)));
        step();
        chk("ovf_done_wr", 32'(fifo_wr), 32'd0);

        // Occupancy edge: one free slot, in-flight write must block the next grant
        do_reset();
        usedw = 9'd255;
        strobe(0, desc(1'b0, 4'd0, 9'd40));
        strobe(3, desc(1'b0, 4'd3, 9'd43));
        step();
        idle();
        chk("occ_lat_wr", 32'(fifo_wr), 32'd0);
        step();
        chk("occ_p0_wr",   32'(fifo_wr),    32'd1);
        chk("occ_p0_data", 32'(fifo_wdata), 32'(desc(1'b0, 4'd0, 9'd40)));
        step();
        chk("occ_inflight_stall", 32'(fifo_wr), 32'd0);
        usedw = 9'd256;
        step();
        chk("occ_full_stall1", 32'(fifo_wr), 32'd0);
        step();
        chk("occ_full_stall2", 32'(fifo_wr), 32'd0);
        usedw = 9'd254;
        step();
        chk("occ_p3_wr",   32'(fifo_wr),    32'd1);
        chk("occ_p3_data", 32'(fifo_wdata), 32'(desc(1'b0, 4'd3, 9'd43)));
        step();
        chk("occ_done_wr", 32'(fifo_wr), 32'd0);

        // Full buffer push coinciding with a pop
        usedw = 9'd256;
        strobe(2, desc(1'b1, 4'd2, 9'd50));
        step();
        strobe(2, desc(1'b1, 4'd2, 9'd51));
        step();
        idle();
        chk("fpp_hold_wr", 32'(fifo_wr), 32'd0);
        usedw = 9'd0;
        strobe(2, desc(1'b1, 4'd2, 9'd52));
        step();
        idle();
        chk("fpp_a_data", 32'(fifo_wdata), 32'(desc(1'b1, 4'd2, 9'd50)));
        chk("fpp_no_drop", 32'(drop_wr),   32'd0);
        step();
        chk("fpp_b_data", 32'(fifo_wdata), 32'(desc(1'b1, 4'd2, 9'd51)));
        step();
        chk("fpp_c_wr",   32'(fifo_wr),    32'd1);
        chk("fpp_c_data", 32'(fifo_wdata), 32'(desc(1'b1, 4'd2, 9'd52)));
        step();
        chk("fpp_done_wr",  32'(fifo_wr),  32'd0);
        chk("fpp_drop_cnt", 32'(drop_cnt), 32'd0);

        // Reset mid-operation discards buffered entries and ignores strobes
        usedw = 9'd256;
        strobe(0, desc(1'b0, 4'd0, 9'd60));
        step();
        strobe(0, desc(1'b0, 4'd0, 9'd61));
        step();
        strobe(0, desc(1'b0, 4'd0, 9'd62));
        step();
        idle();
        chk("mid_pre_drop_cnt", 32'(drop_cnt), 32'd1);
        rst = 1'b1;
        strobe(1, desc(1'b0, 4'd1, 9'd77));
        step();
        idle();
        rst   = 1'b0;
        usedw = 9'd0;
        chk("mid_rst_wr",       32'(fifo_wr),    32'd0);
        chk("mid_rst_data",     32'(fifo_wdata), 32'd0);
        chk("mid_rst_drop_wr",  32'(drop_wr),    32'd0);
        chk("mid_rst_bufid",    32'(drop_bufid[31:0]), 32'd0);
        chk("mid_rst_drop_cnt", 32'(drop_cnt),   32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mid_after_wr", 32'(fifo_wr), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
